// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_capture
//  Purpose  : Measures high time and period of a PWM waveform once per period
//             and flags a stuck input through a period timeout.
//  Options  : define PWM_CAP_GLITCH_FILT_EN to add a 3-sample glitch filter.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_capture #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    input  logic             clear,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             timeout,
    output logic             level
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   w_s;
    logic                   r_s_d;
    logic                   w_rise;
    logic                   w_fall;

    state_t           r_state,      w_state_nxt;
    logic [CNT_W-1:0] r_per,        w_per_nxt;
    logic [CNT_W-1:0] r_hi,         w_hi_nxt;
    logic [CNT_W-1:0] r_high_cnt,   w_high_nxt;
    logic [CNT_W-1:0] r_period_cnt, w_period_nxt;
    logic             r_meas_valid, w_valid_nxt;
    logic             r_timeout,    w_timeout_nxt;
    logic [CNT_W-1:0] w_per_inc;
    logic             w_per_max;

    generate
        if (SYNC_STAGES == 1) begin : g_sync_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sync <= '0;
                else        r_sync <= pwm_in;
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sync <= '0;
                else        r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            end
        end
    endgenerate

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PWM_CAP_GLITCH_FILT_EN
    // Two history flops plus the live sample give three agreeing samples, so
    // the filtered level moves only two edges later than the raw one.
    logic [1:0] r_hist;
    logic       r_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_held <= 1'b0;
        end else begin
            r_hist <= {r_hist[0], w_sync};
            r_held <= w_s;
        end
    end

    always_comb begin
        w_s = r_held;
        if (w_sync && (&r_hist))
            w_s = 1'b1;
        else if (!w_sync && !(|r_hist))
            w_s = 1'b0;
    end
`else
    assign w_s = w_sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_s_d <= 1'b0;
        else        r_s_d <= w_s;
    end

    assign w_rise    = w_s & ~r_s_d;
    assign w_fall    = ~w_s & r_s_d;
    assign w_per_max = (r_per == c_cnt_max);
    assign w_per_inc = w_per_max ? r_per : r_per + c_cnt_one;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_per        <= '0;
            r_hi         <= '0;
            r_high_cnt   <= '0;
            r_period_cnt <= '0;
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_per        <= w_per_nxt;
            r_hi         <= w_hi_nxt;
            r_high_cnt   <= w_high_nxt;
            r_period_cnt <= w_period_nxt;
            r_meas_valid <= w_valid_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_per_nxt     = r_per;
        w_hi_nxt      = r_hi;
        w_high_nxt    = r_high_cnt;
        w_period_nxt  = r_period_cnt;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;

        if (clear) begin
            w_state_nxt  = ST_IDLE;
            w_per_nxt    = '0;
            w_hi_nxt     = '0;
            w_high_nxt   = '0;
            w_period_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_per_nxt   = c_cnt_one;
                        w_hi_nxt    = c_cnt_one;
                        w_state_nxt = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_per_max && !w_rise) begin
                        w_timeout_nxt = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_per_nxt = w_per_inc;
                        if (w_fall) w_state_nxt = ST_LOW;
                        else        w_hi_nxt    = r_hi + c_cnt_one;
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        // Report closes the old period and opens the next one
                        w_high_nxt   = r_hi;
                        w_period_nxt = r_per;
                        w_valid_nxt  = 1'b1;
                        w_per_nxt    = c_cnt_one;
                        w_hi_nxt     = c_cnt_one;
                        w_state_nxt  = ST_HIGH;
                    end else if (w_per_max) begin
                        w_timeout_nxt = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_per_nxt = w_per_inc;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign high_cnt   = r_high_cnt;
    assign period_cnt = r_period_cnt;
    assign meas_valid = r_meas_valid;
    assign timeout    = r_timeout;
    assign level      = w_s;

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
# pwm_capture

Downstream measurement stage for the 4-bit-duty PWM generator: samples its `m` output and, once per PWM period, reports the high time and the period length in clock cycles. The block sits on the same clock as the generator and lets a bench or a supervisor check that the commanded duty appears on the wire. It also detects a stuck output (0 % or 100 % duty, or a dead generator) through a timeout.

## Interface
- `CNT_W`, default 8: width of the high-time and period counters; must be at least 5.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `pwm_in`; must be at least 1.
- `clk` input, 1 bit: the single clock; all logic is rising-edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `pwm_in` input, 1 bit: the PWM waveform (the generator's `m`).
- `clear` input, 1 bit: synchronous abort of the current measurement and clear of all results.
- `high_cnt` output, `CNT_W` bits: high cycles in the last complete period.
- `period_cnt` output, `CNT_W` bits: cycles from one rising edge to the next rising edge.
- `meas_valid` output, 1 bit: one-cycle pulse when `high_cnt`/`period_cnt` update.
- `timeout` output, 1 bit: one-cycle pulse when no rising edge arrives within 2^`CNT_W`−1 cycles.
- `level` output, 1 bit: current filtered and synchronized input level `s`.

## Operation
- **Input path**
  - `pwm_in` passes through `SYNC_STAGES` flops, then the optional filter, to give `s`.
  - `s_d` is `s` delayed by one cycle.
  - rise = `s & ~s_d`; fall = `~s & s_d`.
- **Counters**
  - `per` and `hi` are `CNT_W`-bit internal counters.
  - `per` saturates at MAX = 2^`CNT_W`−1.
- **FSM states:** IDLE, HIGH, LOW.
- **IDLE**
  - On rise: `per` ← 1, `hi` ← 1, go to HIGH.
  - A fall, or a constant level, does nothing.
- **HIGH**
  - Each cycle: `per` ← `per`+1.
  - While `s`=1: `hi` ← `hi`+1.
  - On fall: go to LOW; `hi` does not increment.
- **LOW**
  - Each cycle: `per` ← `per`+1.
  - On rise, all of the following happen at the same edge:
    - `high_cnt` ← `hi`, `period_cnt` ← `per`.
    - `meas_valid` ← 1.
    - `per` ← 1, `hi` ← 1.
    - Go to HIGH.
- **Timeout (HIGH or LOW)**
  - Fires when `per` = MAX and no rise arrives this cycle.
  - Action: `timeout` ← 1 for one cycle, go to IDLE.
  - `high_cnt`/`period_cnt` keep their last values.
- **Clear**
  - State → IDLE; `per`, `hi`, `high_cnt`, `period_cnt` ← 0.
  - No `meas_valid` or `timeout` pulse.
  - `clear` overrides a rise or timeout in the same cycle.
  - The synchronizer, filter and `level` are unaffected.
- **First period:** the first rise after reset, clear or timeout only arms the block; the first `meas_valid` follows the second rise.
- **Minimum waveform:** a 1-cycle high and a 1-cycle low (at `s`) are measured correctly: `high_cnt`=1, `period_cnt`=2.

## Timing
- **Reset values:**
  - `high_cnt`=0, `period_cnt`=0, `meas_valid`=0, `timeout`=0, `level`=0.
  - State IDLE; synchronizer and filter flops all 0.
- **Input latency:** a `pwm_in` edge reaches `s` after `SYNC_STAGES` clock edges, plus 2 more when the filter is compiled in.
- **Result latency:** results, `meas_valid` and `timeout` are registered. They change on the edge at which the FSM sees the rise or timeout, and are visible in the following cycle.
- **Output stability:** `high_cnt`/`period_cnt` are stable between `meas_valid` pulses. `meas_valid` never lasts more than one cycle.
- **Back-to-back pulses:** `meas_valid` and `timeout` are never both high in the same cycle.

## Configuration
- **Macro:** `PWM_CAP_GLITCH_FILT_EN`.
- **Defined:**
  - `s` changes only after the synchronized input has held the new value for 3 consecutive samples.
  - Pulses of 1–2 cycles are ignored.
  - Latency increases by 2 cycles.
  - The minimum measurable high or low width is 3 cycles.
- **Undefined:** `s` is the synchronizer output directly; there is no filtering.

## Test plan
- **Steady PWM:** period 16, high 5 on `pwm_in`, `CNT_W`=8 → `meas_valid` once per 16 cycles, starting at the second rise; `high_cnt`=5, `period_cnt`=16 each time.
- **Duty change:** steps high time 3 → 12 at a period boundary → the next report is 3/16, then 12/16. No report mixes the two.
- **Stuck input:** `pwm_in` held 0 after one rise → `timeout` pulses once exactly 255 cycles after that rise is seen. The state returns to IDLE and `high_cnt`/`period_cnt` keep their previous values. Holding `pwm_in` at 1 gives the same result with `level`=1.
- **Clear during LOW:** assert `clear` in LOW, coincident with a rise → outputs go to 0 with no `meas_valid`. The next report comes two rises later.
- **Reset mid-period:** drop `rst_n` mid-period → all outputs go to 0 immediately. After release, the first report follows the second rise.
- **Glitch (`PWM_CAP_GLITCH_FILT_EN` defined):** 1-cycle high glitches inside the low phase of a 16/5 waveform → reports stay 5/16. With the macro undefined, the glitch produces extra reports.
